// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the SDRAM PLL reset sequencer.
// Optional feature macro used by the top level: PLL_SEQ_LOSS_COUNT_EN.
package pll_seq_pkg;

    // Sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } seq_state_e;

    localparam int RETRY_W = 8;
    localparam int LOSS_W  = 16;

    // Counter width: enough bits for the largest terminal count, plus one.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer, asynchronous active-low reset to 0.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the downstream reset. Retries on timeout, faults after
// MAX_RETRIES failed attempts, and re-runs on lock loss or relock_req.
// Optional macro PLL_SEQ_LOSS_COUNT_EN adds a saturating lock-loss counter.
//
// Handshake: relock_req is a single-cycle pulse, sampled on every clk edge,
// with priority over every other condition; there is no ready/ack back.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRIES  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               sys_reset_n,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
`ifdef PLL_SEQ_LOSS_COUNT_EN
    output logic [LOSS_W-1:0]  loss_cnt,
`endif
    output logic [2:0]         dbg_state
);

    localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

    seq_state_e         r_state;
    seq_state_e         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic [RETRY_W-1:0] w_retry_inc;
    logic               w_locked_s;
    logic               r_pll_rst;
    logic               r_sys_reset_n;
    logic               r_ready;
    logic               r_fault;

    // Lock flag comes from the PLL's own domain; only the synchronized copy is used.
    sync_2ff u_lock_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_d     (pll_locked),
        .o_q     (w_locked_s)
    );

    assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_retry_inc = (r_retry == RETRY_SAT) ? r_retry : r_retry + RETRY_W'(1);

    // Next-state logic; relock_req overrides everything and wipes all counts.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        if (relock_req) begin
            w_state_nxt = RESET_PLL;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
        end else begin
            case (r_state)
                RESET_PLL: begin
                    if (r_cnt >= RST_LAST) begin
                        w_state_nxt = WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_state_nxt = STABILIZE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= TO_LAST) begin
                        w_retry_nxt = w_retry_inc;
                        w_cnt_nxt   = '0;
                        w_state_nxt = (w_retry_inc >= RETRY_MAX) ? FAULT : RESET_PLL;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                STABILIZE: begin
                    // A dropout is not a retry: go back and restart the timeout window.
                    if (!w_locked_s) begin
                        w_state_nxt = WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= STB_LAST) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = '0;
                        w_retry_nxt = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                RUN: begin
                    if (!w_locked_s) begin
                        w_state_nxt = RESET_PLL;
                        w_cnt_nxt   = '0;
                    end
                end
                FAULT: begin
                    w_state_nxt = FAULT;
                end
                default: begin
                    w_state_nxt = RESET_PLL;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = '0;
                end
            endcase
        end
    end

    // State, counters and outputs; outputs are decoded from the next state so
    // they change on the same edge as the state and never depend on inputs directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= RESET_PLL;
            r_cnt         <= '0;
            r_retry       <= '0;
            r_pll_rst     <= 1'b1;
            r_sys_reset_n <= 1'b0;
            r_ready       <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_retry       <= w_retry_nxt;
            r_pll_rst     <= (w_state_nxt == RESET_PLL) || (w_state_nxt == FAULT);
            r_sys_reset_n <= (w_state_nxt == RUN);
            r_ready       <= (w_state_nxt == RUN);
            r_fault       <= (w_state_nxt == FAULT);
        end
    end

`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic              w_loss_evt;
    logic [LOSS_W-1:0] r_loss;

    // Only a genuine lock loss out of RUN counts; a coincident relock_req wins.
    assign w_loss_evt = (r_state == RUN) && !w_locked_s && !relock_req;

    // Saturating loss counter, cleared only by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_loss <= '0;
        end else if (w_loss_evt && (r_loss != '1)) begin
            r_loss <= r_loss + LOSS_W'(1);
        end
    end

    assign loss_cnt = r_loss;
`endif

    assign pll_rst     = r_pll_rst;
    assign sys_reset_n = r_sys_reset_n;
    assign ready       = r_ready;
    assign fault       = r_fault;
    assign retry_cnt   = r_retry;
    assign dbg_state   = r_state;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sequences bring-up of the SDRAM clock PLL (50 MHz ref in, 200 MHz out).
- Drives the PLL reset, watches the PLL lock flag and waits for lock to be stable.
- Releases the system/SDRAM-controller reset only after stable lock; re-runs on lock loss or software request.
- Sits between the board reset input, the PLL wrapper and the Qsys reset network; runs on the free-running 50 MHz reference clock.

Parameters:
- RST_CYCLES, 16: clk cycles `pll_rst` is held high per attempt (≥1).
- LOCK_TIMEOUT, 65536: clk cycles allowed in WAIT_LOCK before a retry (≥2).
- LOCK_STABLE, 1024: consecutive synchronized-lock cycles required before release (≥1).
- MAX_RETRIES, 4: failed attempts before entering FAULT (1..255).

Ports:
- clk, input, 1: 50 MHz reference clock; also feeds the PLL `refclk`.
- reset_n, input, 1: asynchronous active-low reset.
- pll_locked, input, 1: PLL lock flag; asynchronous to clk.
- relock_req, input, 1: single-cycle pulse; forces a full re-sequence.
- pll_rst, output, 1: active-high PLL reset.
- sys_reset_n, output, 1: active-low downstream reset.
- ready, output, 1: high while in RUN.
- fault, output, 1: high while in FAULT.
- retry_cnt, output, 8: failed attempts in the current bring-up.

Behaviour:
- Interface: one clock, `clk`. Reset `reset_n` is asynchronous, active-low. All state registers reset asynchronously.
- Reset values: `pll_rst`=1, `sys_reset_n`=0, `ready`=0, `fault`=0, `retry_cnt`=0, state=RESET_PLL, counters=0.
- `sys_reset_n` asserts asynchronously (with `reset_n`) and deasserts synchronously to clk. Synchronizing it into the 200 MHz domain is the consumer's job.
- `pll_locked` passes through a 2-FF synchronizer to give `locked_s`; this adds 2 cycles of latency. Only `locked_s` is used below.
- RESET_PLL:
  - `pll_rst`=1, `sys_reset_n`=0.
  - Hold exactly RST_CYCLES cycles, then go to WAIT_LOCK with the counter cleared.
- WAIT_LOCK:
  - `pll_rst`=0.
  - If `locked_s`=1: go to STABILIZE.
  - Else, when counter = LOCK_TIMEOUT-1: increment `retry_cnt`.
  - If the new `retry_cnt` = MAX_RETRIES: go to FAULT. Otherwise go to RESET_PLL.
- STABILIZE:
  - Count consecutive `locked_s`=1 cycles.
  - If `locked_s`=0: go to WAIT_LOCK with the counter cleared. This is not a retry; the timeout restarts.
  - At count = LOCK_STABLE: go to RUN.
- RUN:
  - `sys_reset_n`=1, `ready`=1, `retry_cnt` cleared on entry.
  - First RUN cycle has `sys_reset_n`=1, i.e. release is 1 cycle after the final stable cycle.
  - If `locked_s`=0: go to RESET_PLL. `sys_reset_n`=0 and `ready`=0 are registered on that same edge.
- FAULT:
  - `pll_rst`=1, `sys_reset_n`=0, `fault`=1.
  - Stays until `relock_req` or `reset_n`.
- `relock_req` has the highest priority in every state. It sends the block to RESET_PLL and clears all counters and `retry_cnt`.
- Simultaneous `relock_req` and lock loss give the same result as `relock_req` alone.
- Counters saturate and never wrap. Counter width is $clog2 of the largest of RST_CYCLES, LOCK_TIMEOUT and LOCK_STABLE, plus 1.
- All outputs are registered; no combinational path from any input to any output.
- `reset_n` asserted mid-operation returns every output to its reset value immediately.

Optional Feature:
- Macro: PLL_SEQ_LOSS_COUNT_EN.
- Defined:
  - Adds output `loss_cnt` [15:0], a saturating count of RUN→RESET_PLL transitions caused by lock loss.
  - Reset to 0 by `reset_n` only; not cleared by `relock_req`.
  - Saturates at 16'hFFFF.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package `pll_seq_pkg`:
  - State enum {RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAULT}, 3-bit encoding.
  - RETRY_W=8 and LOSS_W=16 constants.
  - Counter-width function.
- Sub-module `sync_2ff`: generic 1-bit two-flop synchronizer with async active-low reset (resets to 0). Instantiated for `pll_locked`.

Test Plan:
- Params RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, MAX_RETRIES=3.
- Reset, then `pll_locked` rises at cycle 10 and stays high → `pll_rst` high for exactly 4 cycles after reset release; `sys_reset_n` and `ready` rise 2+8+1 cycles after the `pll_locked` edge; `retry_cnt`=0.
- `pll_locked` held at 0 → three 32-cycle timeouts; `retry_cnt` steps 1,2,3; `fault`=1; `pll_rst`=1 thereafter. A `relock_req` pulse then clears `fault` and `retry_cnt`, and `pll_rst` is held for 4 cycles.
- Lock glitches low for 1 cycle during STABILIZE at stable count 5 → no release. The stable count restarts; release occurs 8 stable cycles after lock returns; `retry_cnt` unchanged.
- In RUN, drop `pll_locked` → `sys_reset_n` goes 0 three cycles later (2 sync + 1 register); `pll_rst` pulses for 4 cycles; re-lock gives a normal release. With PLL_SEQ_LOSS_COUNT_EN, `loss_cnt`=1.
- Assert `reset_n`=0 during STABILIZE → all outputs return to reset values asynchronously (no clk edge needed); a clean sequence follows deassertion.
- `relock_req` on the same cycle as lock loss in RUN → single RESET_PLL entry with `retry_cnt`=0; with the macro defined, `loss_cnt` unchanged.
